// File: rtl/serial_add_sub.sv
// serial_add_sub: bit-serial adder/subtractor behind a start/done handshake.
// One full-adder slice processes the operands LSB-first, one bit per clock.
// The carry is kept in a flip-flop between bits.
// Subtraction is A + ~B + 1: B is inverted on load and the carry starts at 1.
module serial_add_sub #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             cout,
   output logic             ovf
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   state_t           nstate;
   logic             accept;
   logic             lastbit;
   logic [WIDTH-1:0] sa;
   logic [WIDTH-1:0] sb;
   logic [WIDTH-1:0] acc;
   logic             carry;
   logic [CW-1:0]    cnt;
   logic             sum;
   logic             cnext;

   // A new operation may only start from IDLE, or back-to-back from DONE.
   assign accept  = start && ((state == IDLE) || (state == DONE));
   assign lastbit = (cnt == CW'(WIDTH - 1));

   // Full-adder slice working on the current LSBs and the stored carry.
   always_comb begin
      sum   = sa[0] ^ sb[0] ^ carry;
      cnext = (sa[0] & sb[0]) | (sa[0] & carry) | (sb[0] & carry);
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= nstate;
      end
   end

   // Next-state logic: RUN lasts WIDTH cycles and DONE lasts one cycle.
   always_comb begin
      nstate = state;
      case (state)
         IDLE:    nstate = accept ? RUN : IDLE;
         RUN:     nstate = lastbit ? DONE : RUN;
         DONE:    nstate = accept ? RUN : IDLE;
         default: nstate = IDLE;
      endcase
   end

   // Handshake outputs are decoded from the state alone.
   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      case (state)
         RUN:     busy = 1'b1;
         DONE:    done = 1'b1;
         default: begin
            busy = 1'b0;
            done = 1'b0;
         end
      endcase
   end

   // Operand load, serial shift, carry update and bit count.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sa    <= '0;
         sb    <= '0;
         acc   <= '0;
         carry <= 1'b0;
         cnt   <= '0;
      end else if (accept) begin
         sa    <= a;
         sb    <= b ^ {WIDTH{sub}};
         carry <= sub;
         cnt   <= '0;
      end else if (state == RUN) begin
         sa    <= sa >> 1;
         sb    <= sb >> 1;
         acc   <= {sum, acc[WIDTH-1:1]};
         carry <= cnext;
         cnt   <= cnt + 1'b1;
      end
   end

   // Publish the result on the MSB cycle so it only changes on the DONE-entry edge.
   // On that cycle the stored carry is the carry into the MSB, so ovf compares it with the carry out.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         result <= '0;
         cout   <= 1'b0;
         ovf    <= 1'b0;
      end else if ((state == RUN) && lastbit) begin
         result <= {sum, acc[WIDTH-1:1]};
         cout   <= cnext;
         ovf    <= carry ^ cnext;
      end
   end

endmodule

// File: tb/tb_serial_add_sub.sv
// Testbench for serial_add_sub (WIDTH=8).
// A driver issues operations and pushes the expected responses onto a scoreboard queue.
// A monitor checks the DUT outputs on every falling edge.
module tb_serial_add_sub;

   localparam int W = 8;

   logic         clk;
   logic         rst;
   logic         start;
   logic         sub;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         busy;
   logic         done;
   logic [W-1:0] result;
   logic         cout;
   logic         ovf;

   typedef struct {
      logic [W-1:0] res;
      logic         co;
      logic         ov;
      int           startCyc;
   } exp_t;

   exp_t         sbq[$];
   int           cyc;
   int           nCompared;
   int           nMismatched;
   logic [W-1:0] lastRes;
   logic         lastCo;
   logic         lastOv;

   serial_add_sub #(.WIDTH(W)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .sub    (sub),
      .a      (a),
      .b      (b),
      .busy   (busy),
      .done   (done),
      .result (result),
      .cout   (cout),
      .ovf    (ovf)
   );

   // Free-running clock with a 10 ns period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Cycle counter used to measure the latency from Start to Done.
   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Compare one value, count it, and report any mismatch.
   task automatic checkOutput(input string name, input logic [W-1:0] actual, input logic [W-1:0] expected);
      nCompared++;
      if (actual !== expected) begin
         nMismatched++;
         $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, actual, expected, $time);
      end
   endtask

   // Reference model built from plain integer and signed arithmetic.
   function automatic exp_t model(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic ts);
      exp_t e;
      int   ua;
      int   ub;
      int   sa;
      int   sbv;
      int   ures;
      int   sres;
      ua = int'(ta);
      ub = int'(tb);
      sa = int'($signed(ta));
      sbv = int'($signed(tb));
      ures = ts ? (ua - ub) : (ua + ub);
      sres = ts ? (sa - sbv) : (sa + sbv);
      e.res = W'(ures & 255);
      e.co = ts ? (ua >= ub) : (ures > 255);
      e.ov = (sres > 127) || (sres < -128);
      e.startCyc = 0;
      return e;
   endfunction

   // Drive one request starting at a falling edge, then record it once the accepting edge has passed.
   task automatic applyStimulus(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic ts);
      exp_t e;
      start = 1'b1;
      a = ta;
      b = tb;
      sub = ts;
      @(posedge clk);
      #1;
      e = model(ta, tb, ts);
      e.startCyc = cyc;
      sbq.push_back(e);
      start = 1'b0;
      a = $urandom;
      b = $urandom;
      sub = $urandom;
   endtask

   // Wait, with a cycle budget, for the falling edge at which Done is high.
   task automatic waitDone();
      bit seen;
      seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         if (done === 1'b1) seen = 1;
      end
      if (!seen) begin
         nCompared++;
         nMismatched++;
         $display("[TB] FAIL done_timeout: got no Done, expected Done within 20 cycles");
      end
   endtask

   // Monitor: checks the scoreboard, handshake levels, latency and output hold on every falling edge.
   initial begin
      exp_t e;
      lastRes = '0;
      lastCo = 1'b0;
      lastOv = 1'b0;
      forever begin
         @(negedge clk);
         if (done === 1'b1) begin
            checkOutput("busy_at_done", {7'd0, busy}, 8'd0);
            if (sbq.size() == 0) begin
               nCompared++;
               nMismatched++;
               $display("[TB] FAIL unexpected_done: got Done=1, expected no Done");
            end else begin
               e = sbq.pop_front();
               checkOutput("result", result, e.res);
               checkOutput("cout", {7'd0, cout}, {7'd0, e.co});
               checkOutput("ovf", {7'd0, ovf}, {7'd0, e.ov});
               checkOutput("latency", W'(cyc - e.startCyc), 8'd8);
               lastRes = e.res;
               lastCo = e.co;
               lastOv = e.ov;
            end
         end else begin
            checkOutput("busy", {7'd0, busy}, (sbq.size() != 0) ? 8'd1 : 8'd0);
            checkOutput("result_hold", result, lastRes);
            checkOutput("flags_hold", {6'd0, cout, ovf}, {6'd0, lastCo, lastOv});
         end
      end
   end

   // Global time limit so the bench always ends.
   initial begin
      #1000000;
      $display("[TB] FAIL global_timeout: got no finish, expected finish before 1 ms");
      $fatal(1, "[TB] timeout");
   end

   // Driver: directed scenarios first, then the random sweep.
   initial begin
      exp_t e;
      nCompared = 0;
      nMismatched = 0;
      rst = 1'b1;
      start = 1'b0;
      sub = 1'b0;
      a = '0;
      b = '0;
      repeat (2) @(negedge clk);
      checkOutput("rst_busy", {7'd0, busy}, 8'd0);
      checkOutput("rst_done", {7'd0, done}, 8'd0);
      checkOutput("rst_result", result, 8'd0);
      checkOutput("rst_cout", {7'd0, cout}, 8'd0);
      checkOutput("rst_ovf", {7'd0, ovf}, 8'd0);
      rst = 1'b0;
      @(negedge clk);

      applyStimulus(8'h35, 8'h4A, 1'b0); waitDone(); @(negedge clk);
      applyStimulus(8'h7F, 8'h01, 1'b0); waitDone(); @(negedge clk);
      applyStimulus(8'hFF, 8'h01, 1'b0); waitDone(); @(negedge clk);
      applyStimulus(8'h10, 8'h20, 1'b1); waitDone(); @(negedge clk);
      applyStimulus(8'h80, 8'h01, 1'b1); waitDone(); @(negedge clk);
      applyStimulus(8'h55, 8'h55, 1'b1); waitDone(); @(negedge clk);

      // A Start pulse during RUN must be ignored.
      applyStimulus(8'h01, 8'h02, 1'b0);
      repeat (2) @(negedge clk);
      start = 1'b1;
      a = 8'hFF;
      @(negedge clk);
      start = 1'b0;
      waitDone();
      // Start held in the DONE cycle is accepted back-to-back.
      applyStimulus(8'h04, 8'h05, 1'b0);
      waitDone();
      @(negedge clk);

      // An asynchronous reset mid-RUN clears the outputs at once and produces no Done.
      applyStimulus(8'h33, 8'h11, 1'b0);
      repeat (3) @(negedge clk);
      #2;
      rst = 1'b1;
      sbq.delete();
      lastRes = '0;
      lastCo = 1'b0;
      lastOv = 1'b0;
      #1;
      checkOutput("arst_busy", {7'd0, busy}, 8'd0);
      checkOutput("arst_done", {7'd0, done}, 8'd0);
      checkOutput("arst_result", result, 8'd0);
      checkOutput("arst_flags", {6'd0, cout, ovf}, 8'd0);
      @(negedge clk);
      rst = 1'b0;
      applyStimulus(8'h0A, 8'h05, 1'b1);
      waitDone();
      @(negedge clk);

      // Random sweep with a mix of back-to-back and spaced issues.
      for (int i = 0; i < 1000; i++) begin
         applyStimulus(W'($urandom), W'($urandom), 1'($urandom));
         waitDone();
         if ($urandom_range(0, 1) == 0) begin
            repeat ($urandom_range(1, 3)) @(negedge clk);
         end
      end
      repeat (3) @(negedge clk);
      if (sbq.size() != 0) begin
         nCompared++;
         nMismatched++;
         $display("[TB] FAIL leftover: got %0d pending ops, expected 0", sbq.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
